safety_lockstep_unit: RTL
=========================

# safety_lockstep_unit

Parametrised lockstep checker and voter for the safety island core complex: it compares the output bundles (request, address, write data, strobes) of 2 (DMR) or 3 (TMR) replicated cores every cycle and forwards a registered voted bundle toward memory. It detects and attributes mismatches, and drives a resynchronisation handshake with the core-reset/state-restore logic. Repeated or uncorrectable faults escalate to a sticky fatal flag. It sits between the replicated `cv32e40p` instances and the instruction/data/shadow ports of the core wrapper.

## Interface
- `NumCores`, default 3: number of replicated cores; 2 selects DMR (detect only), 3 selects TMR (vote and correct); other values are an elaboration error.
- `DataWidth`, default 72: width of one core's compared bundle.
- `ErrThreshold`, default 4: accumulated corrected-error count that escalates to fatal; must be ≥1.
- `ResyncTimeout`, default 64: cycles allowed for resync before fatal; must be ≥1.
- `CntWidth`, default 16: width of the error counter.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset; one clock, asynchronous, active-high.
- `enable_i` in 1: checking enabled; low forces IDLE.
- `core_bus_i` in NumCores×DataWidth: per-core bundle.
- `core_valid_i` in NumCores: per-core bundle valid; compared like data.
- `voted_bus_o` out DataWidth: registered voted bundle.
- `voted_valid_o` out 1: voted bundle valid.
- `mismatch_o` out 1: one-cycle pulse on a detected mismatch.
- `faulty_core_o` out NumCores: one-hot minority core of the last mismatch; sticky until `clear_i`.
- `resync_req_o` out 1: request to resynchronise cores.
- `resync_done_i` in 1: resync completed.
- `fatal_o` out 1: sticky unrecoverable fault.
- `clear_i` in 1: clears counter, `faulty_core_o`, and fatal.
- `err_cnt_o` out CntWidth: saturating count of detected mismatches.

## Operation
- Compared word per core: {`core_valid_i[k]`, `core_bus_i[k]`}. Pairwise equality eq01, eq02, eq12; eq02 and eq12 are absent for `NumCores`=2.
- TMR:
  - All equal: no mismatch.
  - Exactly one core differs (the other two agree): correctable. Output is the agreeing pair's value. `faulty_core_o` marks the odd core.
  - No pair agrees: uncorrectable, go to FATAL.
- DMR: any difference is uncorrectable. Go to FATAL; output is core 0's value, and `faulty_core_o` = all ones.
- FSM states: IDLE, RUN, RESYNC, FATAL.
  - IDLE: outputs low. If `enable_i`=1, go to RUN next cycle.
  - RUN, no mismatch: forward the vote.
  - RUN, correctable mismatch: pulse `mismatch_o` and increment `err_cnt_o` (saturating at all ones). If the new count ≥ `ErrThreshold`, go to FATAL; otherwise go to RESYNC.
  - RUN, uncorrectable mismatch: pulse `mismatch_o`, increment the counter, go to FATAL.
  - RESYNC: hold `resync_req_o`=1. The internal timer counts from 0. On `resync_done_i`, go to RUN. When the timer reaches `ResyncTimeout`-1 without done, go to FATAL. Mismatches in RESYNC are neither counted nor pulsed.
  - FATAL: `fatal_o`=1 sticky. Only `clear_i` (go to RUN if enabled, else IDLE) or reset leaves it.
- `enable_i`=0 in any state except FATAL: go to IDLE next cycle and drop `resync_req_o`. The counter is kept.
- `clear_i` zeroes `err_cnt_o` and `faulty_core_o`. It has priority over a same-cycle increment; the state transition caused by that mismatch still occurs.

## Timing
- Reset: state IDLE; every output is 0, including `voted_bus_o`, `faulty_core_o`, and `err_cnt_o`.
- Latency is 1 cycle: inputs sampled at edge N appear on `voted_*` after edge N+1. `mismatch_o`, `faulty_core_o`, and the `err_cnt_o` update are aligned with the voted output of the offending sample.
- `voted_valid_o` is forced 0 in IDLE, RESYNC, and FATAL, including the cycle that enters those states from RUN on a mismatch. The offending sample is never forwarded as valid.
- `resync_req_o` rises in the cycle after the mismatch sample edge and falls in the cycle after `resync_done_i` is sampled.
- `resync_done_i` and the timeout in the same cycle: done wins, go to RUN.
- `resync_done_i` outside RESYNC: ignored.
- Asynchronous `rst_i` mid-RESYNC or mid-FATAL: immediate return to reset values. `fatal_o` is cleared only by reset or `clear_i`.

## Test plan
- TMR, all cores equal, 100 random valid bundles: `voted_bus_o` equals the input one cycle later; `mismatch_o`=0; `err_cnt_o`=0.
- TMR, core 1 bit 5 flipped for one sample:
  - voted value equals cores 0/2; `mismatch_o` pulses once; `faulty_core_o`=3'b010; `err_cnt_o`=1.
  - `resync_req_o`=1 until `resync_done_i` asserts 10 cycles later; then RUN and `voted_valid_o` resumes.
- TMR, cores all differ: `fatal_o`=1 one cycle later; `voted_valid_o`=0; `clear_i` returns to RUN with `err_cnt_o`=0.
- `ErrThreshold`=4, four correctable faults each resolved by done: the fourth goes directly to FATAL with `err_cnt_o`=4 and no resync request.
- `ResyncTimeout`=64, no done: `fatal_o` rises 64 cycles after `resync_req_o`. With done and the timeout coincident on the last cycle: RUN, `fatal_o`=0.
- DMR (`NumCores`=2), core 1 `core_valid_i` differs: `fatal_o`=1; `faulty_core_o`=2'b11; async `rst_i` mid-FATAL clears all outputs to 0.

Source files
------------

// File: rtl/safety_lockstep_unit.sv
// ---------------------------------------------------------------------------
// safety_lockstep_unit
//
// Lockstep checker and voter for the replicated cores of the safety island.
// Every cycle it compares the {valid, bundle} words of 2 (DMR) or 3 (TMR)
// cores. It forwards a registered voted bundle and attributes any mismatch
// to a core. It then runs a resynchronisation handshake with the core-reset
// logic, and escalates repeated or uncorrectable faults to a sticky fatal
// state.
//
// Parameters
//   NumCores      : 2 = DMR (detect only), 3 = TMR (vote and correct)
//   DataWidth     : width of one core's compared bundle
//   ErrThreshold  : accumulated error count that escalates to fatal (>= 1)
//   ResyncTimeout : cycles allowed in resync before fatal (>= 1)
//   CntWidth      : width of the saturating error counter
//
// Ports
//   clk_i          in   clock
//   rst_i          in   asynchronous active-high reset
//   enable_i       in   checking enabled; low returns to IDLE (except FATAL)
//   core_bus_i     in   per-core bundles, core k at [k*DataWidth +: DataWidth]
//   core_valid_i   in   per-core bundle valid, compared like data
//   voted_bus_o    out  registered voted bundle
//   voted_valid_o  out  voted bundle valid
//   mismatch_o     out  one-cycle pulse per counted mismatch
//   faulty_core_o  out  minority core of the last mismatch (sticky)
//   resync_req_o   out  resynchronisation request (high in RESYNC)
//   resync_done_i  in   resynchronisation completed
//   fatal_o        out  sticky unrecoverable fault (high in FATAL)
//   clear_i        in   clears counter, faulty_core_o and the fatal state
//   err_cnt_o      out  saturating count of counted mismatches
// ---------------------------------------------------------------------------
module safety_lockstep_unit #(
   parameter int NumCores      = 3,
   parameter int DataWidth     = 72,
   parameter int ErrThreshold  = 4,
   parameter int ResyncTimeout = 64,
   parameter int CntWidth      = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          enable_i,
   input  logic [NumCores*DataWidth-1:0] core_bus_i,
   input  logic [NumCores-1:0]           core_valid_i,
   output logic [DataWidth-1:0]          voted_bus_o,
   output logic                          voted_valid_o,
   output logic                          mismatch_o,
   output logic [NumCores-1:0]           faulty_core_o,
   output logic                          resync_req_o,
   input  logic                          resync_done_i,
   output logic                          fatal_o,
   input  logic                          clear_i,
   output logic [CntWidth-1:0]           err_cnt_o
);

   // ------------------------------------------------------------------------
   // Elaboration-time parameter checks
   // ------------------------------------------------------------------------
   if (NumCores != 2 && NumCores != 3) begin : g_bad_num_cores
      $error("safety_lockstep_unit: NumCores must be 2 or 3");
   end
   if (ErrThreshold < 1) begin : g_bad_threshold
      $error("safety_lockstep_unit: ErrThreshold must be >= 1");
   end
   if (CntWidth < 31 && ErrThreshold > (2 ** CntWidth) - 1) begin : g_bad_cnt_width
      $error("safety_lockstep_unit: ErrThreshold does not fit in CntWidth");
   end
   if (ResyncTimeout < 1) begin : g_bad_timeout
      $error("safety_lockstep_unit: ResyncTimeout must be >= 1");
   end

   localparam bit                    Tmr       = (NumCores == 3);
   localparam int                    TimerW    = (ResyncTimeout > 1) ? $clog2(ResyncTimeout) : 1;
   localparam logic [TimerW-1:0]     TimerLast = TimerW'(ResyncTimeout - 1);
   localparam logic [CntWidth-1:0]   ThreshCnt = CntWidth'(ErrThreshold);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_RESYNC,
      ST_FATAL
   } state_e;

   // ------------------------------------------------------------------------
   // Compared words. The array is always three entries wide. In DMR the
   // third entry is tied off, so the vote logic below is written only once.
   // ------------------------------------------------------------------------
   logic [DataWidth:0] word [3];

   for (genvar k = 0; k < 3; k++) begin : g_word
      if (k < NumCores) begin : g_real
         assign word[k] = {core_valid_i[k], core_bus_i[k*DataWidth +: DataWidth]};
      end else begin : g_tied
         assign word[k] = '0;
      end
   end

   logic eq01, eq02, eq12;

   assign eq01 = (word[0] == word[1]);
   assign eq02 = (word[0] == word[2]);
   assign eq12 = (word[1] == word[2]);

   // ------------------------------------------------------------------------
   // Vote and fault attribution
   // ------------------------------------------------------------------------
   logic [DataWidth:0] vote_word;
   logic               mis_any;
   logic               mis_uncorr;
   logic [2:0]         minority;

   // NOTE: every variable written in an always_comb gets a default first, so
   //       no path can leave it unassigned and infer a latch.
   always_comb begin
      vote_word  = word[0];
      mis_any    = 1'b0;
      mis_uncorr = 1'b0;
      minority   = 3'b000;
      if (Tmr) begin
         if (eq01 && eq02) begin
            // All three agree. Transitivity also implies eq12.
            vote_word = word[0];
         end else if (eq01) begin
            mis_any  = 1'b1;
            minority = 3'b100;
         end else if (eq02) begin
            mis_any  = 1'b1;
            minority = 3'b010;
         end else if (eq12) begin
            mis_any   = 1'b1;
            minority  = 3'b001;
            vote_word = word[1];
         end else begin
            // No majority exists, so no single core can be blamed.
            mis_any    = 1'b1;
            mis_uncorr = 1'b1;
            minority   = 3'b111;
         end
      end else if (!eq01) begin
         // DMR can only detect a difference. Core 0 stays on the output.
         mis_any    = 1'b1;
         mis_uncorr = 1'b1;
         minority   = 3'b111;
      end
   end

   // ------------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------------
   state_e                state_q,       state_d;
   logic [TimerW-1:0]     timer_q,       timer_d;
   logic [CntWidth-1:0]   cnt_q,         cnt_d;
   logic [NumCores-1:0]   faulty_q,      faulty_d;
   logic [DataWidth-1:0]  voted_bus_q,   voted_bus_d;
   logic                  voted_valid_q, voted_valid_d;
   logic                  mismatch_q,    mismatch_d;
   logic [CntWidth-1:0]   cnt_inc;

   assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

   always_comb begin
      state_d       = state_q;
      timer_d       = '0;
      cnt_d         = cnt_q;
      faulty_d      = faulty_q;
      voted_bus_d   = '0;
      voted_valid_d = 1'b0;
      mismatch_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (enable_i) state_d = ST_RUN;
         end

         ST_RUN: begin
            if (!enable_i) begin
               state_d = ST_IDLE;
            end else begin
               voted_bus_d = vote_word[DataWidth-1:0];
               if (mis_any) begin
                  // The offending sample is shown on the bus but never
                  // marked valid.
                  mismatch_d = 1'b1;
                  faulty_d   = minority[NumCores-1:0];
                  cnt_d      = cnt_inc;
                  if (mis_uncorr || cnt_inc >= ThreshCnt) state_d = ST_FATAL;
                  else                                    state_d = ST_RESYNC;
               end else begin
                  voted_valid_d = vote_word[DataWidth];
               end
            end
         end

         ST_RESYNC: begin
            // Done is checked before the timeout, so a done that coincides
            // with the last timer cycle still returns to RUN.
            if (!enable_i)                state_d = ST_IDLE;
            else if (resync_done_i)       state_d = ST_RUN;
            else if (timer_q == TimerLast) state_d = ST_FATAL;
            else                          timer_d = timer_q + 1'b1;
         end

         ST_FATAL: begin
            if (clear_i) state_d = enable_i ? ST_RUN : ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase

      // Clear wins over a same-cycle increment. The state change caused by
      // that mismatch has already been decided above.
      if (clear_i) begin
         cnt_d    = '0;
         faulty_d = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   //       register samples the pre-edge value of every other register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= ST_IDLE;
         timer_q       <= '0;
         cnt_q         <= '0;
         faulty_q      <= '0;
         voted_bus_q   <= '0;
         voted_valid_q <= 1'b0;
         mismatch_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         cnt_q         <= cnt_d;
         faulty_q      <= faulty_d;
         voted_bus_q   <= voted_bus_d;
         voted_valid_q <= voted_valid_d;
         mismatch_q    <= mismatch_d;
      end
   end

   assign voted_bus_o   = voted_bus_q;
   assign voted_valid_o = voted_valid_q;
   assign mismatch_o    = mismatch_q;
   assign faulty_core_o = faulty_q;
   assign err_cnt_o     = cnt_q;
   assign resync_req_o  = (state_q == ST_RESYNC);
   assign fatal_o       = (state_q == ST_FATAL);

endmodule
